bev_ctrl: RTL
=============

BEV_CTRL -- requirements
Module: bev_ctrl

Interface
REQ-001 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- clk  in  1  sole clock; all flops rise-edge
- rst_n  in  1  reset, asynchronous, active-low
- sel_action_valid  in  1  D[1:0] carries action: 0 Make_drink, 1 Supply, 2 Check_Valid_Date
- type_valid  in  1  D[2:0] carries drink type 0..7
- size_valid  in  1  D[1:0] carries size: 0 L, 1 M, 3 S
- date_valid  in  1  D[8:5] month, D[4:0] day
- box_no_valid  in  1  D[7:0] carries box number
- box_sup_valid  in  1  D[9:0] carries one supply amount; four pulses in order BT, GT, M, PJ
- D  in  10  shared user data bus
- C_in_valid  out  1  one-cycle request to bridge
- C_addr  out  8  box number for request
- C_data_w  out  64  request payload
- C_out_valid  in  1  bridge result strobe
- C_data_r  in  64  bit 2 bridge busy, bits 1:0 error code
- out_valid  out  1  one-cycle result strobe to user
- err_msg  out  2  0 No_Err, 1 No_Exp, 2 No_Ing, 3 Ing_OF
- complete  out  1  high with out_valid when err_msg==0
- err_cnt  out  8  saturating error count (see Configuration)

Function
REQ-002 Each valid input SHALL be high exactly one cycle; the block SHALL capture D on that cycle, one field per strobe, and SHALL ignore strobes arriving in an unexpected order.
REQ-003 Field sequences SHALL be: Make_drink = action, type, size, date, box_no; Supply = action, date, box_no, 4x box_sup; Check_Valid_Date = action, date, box_no.
REQ-004 FSM states SHALL be IDLE, COLLECT, ISSUE, WAIT_RESP, OUT; IDLE->COLLECT on sel_action_valid; COLLECT->ISSUE on the last field of the sequence.
REQ-005 In ISSUE the block SHALL assert C_in_valid for exactly one cycle, only when C_data_r[2]==0 and C_out_valid==0 and no previous request is pending the bridge-idle condition of REQ-011; otherwise it SHALL hold in ISSUE.
REQ-006 The earliest C_in_valid SHALL be the cycle after the last field strobe.
REQ-007 C_data_w SHALL be {action-type encoding in [63:62] (Make 2'b00, Supply 2'b01, Check 2'b10), zeros [61:57], month [56:53], day [52:48], zeros [47:40], BT [39:30], GT [29:20], M [19:10], PJ [9:0]}; C_addr = box_no; both SHALL be stable from C_in_valid until C_out_valid.
REQ-008 For Make_drink, the four amounts SHALL be recipe amounts at size volume V (L 960, M 720, S 480):
- type 0 BT=V
- type 1 BT=3V/4, M=V/4
- type 2 BT=M=V/2
- type 3 GT=V
- type 4 GT=M=V/2
- type 5 PJ=V
- type 6 BT=PJ=V/2
- type 7 BT=V/2, M=PJ=V/4
- All other amounts 0; all values SHALL be exact 10-bit constants.
REQ-009 For Supply, the amounts SHALL be the four captured box_sup values; for Check_Valid_Date, the amounts SHALL be 0.
REQ-010 WAIT_RESP->OUT on C_out_valid; err_msg is captured from C_data_r[1:0]. In OUT, out_valid=1 for one cycle, then the FSM returns to IDLE.
REQ-011 After any C_out_valid, the next C_in_valid SHALL NOT occur until C_data_r[2] has been sampled 0 on a cycle strictly later than the C_out_valid cycle.
REQ-012 A new sel_action_valid arriving while the FSM is in OUT or while the bridge is busy SHALL be accepted; fields SHALL be collected and issue deferred per REQ-005/011. No field SHALL be lost.
REQ-013 out_valid, err_msg and complete SHALL be 0 whenever out_valid is not asserted.

Reset
REQ-014 On rst_n low, the FSM SHALL go to IDLE and all outputs, captured fields and the busy-pending flag SHALL clear to 0 immediately; a transaction in flight SHALL be abandoned without out_valid.

Configuration
REQ-015 Macro BEV_ERR_CNT_EN: when defined, err_cnt SHALL increment on each out_valid with err_msg!=0, saturating at 255; when undefined, err_cnt SHALL be constant 0 and no counter logic is built.

Verification
REQ-016 Make_drink, type 1, size L, date 3/15, box 5, bridge returns 0 -> C_addr=5, C_data_w[39:30]=720, [19:10]=240, [63:62]=0; out_valid with err_msg=0, complete=1.
REQ-017 Supply, date 12/31, box 255, sups 1,2,3,1023 -> C_data_w[63:62]=1, [56:53]=12, [52:48]=31, PJ field=1023; bridge code 3 -> err_msg=3, complete=0.
REQ-018 A back-to-back Check_Valid_Date is collected while C_data_r[2] is held 1 for 6 cycles after C_out_valid -> C_in_valid is asserted only after busy falls, with exactly one pulse.
REQ-019 Make_drink, type 7, size S -> BT=240, M=120, PJ=120, GT=0.
REQ-020 Reset is asserted in WAIT_RESP -> outputs are 0 at once, there is no out_valid, and the next transaction completes normally.
REQ-021 With BEV_ERR_CNT_EN, 300 error results -> err_cnt=255; without the macro, err_cnt stays 0.

Source files
------------

// File: rtl/bev_ctrl.sv
// Beverage controller: collects a user command field by field, issues one bridge request, reports the result.
// Latency: request is issued the cycle after the last field strobe when the bridge is idle; result one cycle after C_out_valid.
// Backpressure: requests are held in ISSUE while the bridge is busy, is responding, or has not yet shown idle after its last response.
// Optional feature: define BEV_ERR_CNT_EN to build the saturating error counter on err_cnt.
module bev_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel_action_valid,
  input  logic        type_valid,
  input  logic        size_valid,
  input  logic        date_valid,
  input  logic        box_no_valid,
  input  logic        box_sup_valid,
  input  logic [9:0]  D,
  output logic        C_in_valid,
  output logic [7:0]  C_addr,
  output logic [63:0] C_data_w,
  input  logic        C_out_valid,
  input  logic [63:0] C_data_r,
  output logic        out_valid,
  output logic [1:0]  err_msg,
  output logic        complete,
  output logic [7:0]  err_cnt
);

  localparam logic [1:0] ACT_MAKE = 2'd0;
  localparam logic [1:0] ACT_SUP  = 2'd1;
  localparam logic [1:0] ACT_CHK  = 2'd2;

  typedef enum logic [2:0] {IDLE, COLLECT, ISSUE, WAIT_RESP, OUT} state_t;
  typedef enum logic [2:0] {F_NONE, F_TYPE, F_SIZE, F_DATE, F_BOX, F_SUP} field_t;

  state_t      state;
  state_t      state_nxt;
  field_t      exp_fld;
  logic        fld_last;
  logic        fld_take;
  logic        start_take;
  logic        issue_ok;
  logic        in_req;

  logic [1:0]  action;
  logic [2:0]  dtype;
  logic [1:0]  size;
  logic [3:0]  month;
  logic [4:0]  day;
  logic [7:0]  box_no;
  logic [9:0]  sup_bt;
  logic [9:0]  sup_gt;
  logic [9:0]  sup_m;
  logic [9:0]  sup_pj;
  logic [2:0]  step;
  logic [1:0]  sup_idx;
  logic        busy_pend;
  logic [1:0]  err_q;
  logic [39:0] amounts;
  logic [63:0] payload;

  // Only the error code and busy bit of the bridge read data carry meaning here.
  logic unused_data_r;
  assign unused_data_r = ^C_data_r[63:3];

  // Recipe table: {BT, GT, M, PJ} for a drink type at the volume set by the size code.
  function automatic logic [39:0] recipe(input logic [2:0] t, input logic [1:0] s);
    logic [9:0] v_full, v_3q, v_half, v_q;
    logic [39:0] r;
    case (s)
      2'd0:    begin v_full = 10'd960; v_3q = 10'd720; v_half = 10'd480; v_q = 10'd240; end
      2'd1:    begin v_full = 10'd720; v_3q = 10'd540; v_half = 10'd360; v_q = 10'd180; end
      2'd3:    begin v_full = 10'd480; v_3q = 10'd360; v_half = 10'd240; v_q = 10'd120; end
      default: begin v_full = 10'd0;   v_3q = 10'd0;   v_half = 10'd0;   v_q = 10'd0;   end
    endcase
    case (t)
      3'd0:    r = {v_full, 10'd0,   10'd0,  10'd0};
      3'd1:    r = {v_3q,   10'd0,   v_q,    10'd0};
      3'd2:    r = {v_half, 10'd0,   v_half, 10'd0};
      3'd3:    r = {10'd0,  v_full,  10'd0,  10'd0};
      3'd4:    r = {10'd0,  v_half,  v_half, 10'd0};
      3'd5:    r = {10'd0,  10'd0,   10'd0,  v_full};
      3'd6:    r = {v_half, 10'd0,   10'd0,  v_half};
      default: r = {v_half, 10'd0,   v_q,    v_q};
    endcase
    return r;
  endfunction

  // A new command is accepted from IDLE or while the previous result is being reported.
  assign start_take = sel_action_valid && (D[1:0] != 2'd3) &&
                      ((state == IDLE) || (state == OUT));

  // The bridge may take a request only when idle, not answering, and idle has been seen since its last answer.
  assign issue_ok = !C_data_r[2] && !C_out_valid && !busy_pend;

  // Decode which field strobe the current command expects next, and whether it closes the sequence.
  always_comb begin
    exp_fld  = F_NONE;
    fld_last = 1'b0;
    if (state == COLLECT) begin
      case (action)
        ACT_MAKE: begin
          case (step)
            3'd0:    exp_fld = F_TYPE;
            3'd1:    exp_fld = F_SIZE;
            3'd2:    exp_fld = F_DATE;
            3'd3:    begin exp_fld = F_BOX; fld_last = 1'b1; end
            default: exp_fld = F_NONE;
          endcase
        end
        ACT_SUP: begin
          case (step)
            3'd0:    exp_fld = F_DATE;
            3'd1:    exp_fld = F_BOX;
            3'd2,
            3'd3,
            3'd4:    exp_fld = F_SUP;
            3'd5:    begin exp_fld = F_SUP; fld_last = 1'b1; end
            default: exp_fld = F_NONE;
          endcase
        end
        ACT_CHK: begin
          case (step)
            3'd0:    exp_fld = F_DATE;
            3'd1:    begin exp_fld = F_BOX; fld_last = 1'b1; end
            default: exp_fld = F_NONE;
          endcase
        end
        default: exp_fld = F_NONE;
      endcase
    end
  end

  // A field is taken only on the strobe that matches the expected field; others are ignored.
  always_comb begin
    fld_take = 1'b0;
    case (exp_fld)
      F_TYPE:  fld_take = type_valid;
      F_SIZE:  fld_take = size_valid;
      F_DATE:  fld_take = date_valid;
      F_BOX:   fld_take = box_no_valid;
      F_SUP:   fld_take = box_sup_valid;
      default: fld_take = 1'b0;
    endcase
  end

  // Supply amounts occupy steps 2..5 and map to BT, GT, M, PJ in that order.
  assign sup_idx = step[1:0] - 2'd2;

  // Next-state and request strobe.
  always_comb begin
    state_nxt  = state;
    C_in_valid = 1'b0;
    case (state)
      IDLE:      if (start_take) state_nxt = COLLECT;
      COLLECT:   if (fld_take && fld_last) state_nxt = ISSUE;
      ISSUE: begin
        if (issue_ok) begin
          C_in_valid = 1'b1;
          state_nxt  = WAIT_RESP;
        end
      end
      WAIT_RESP: if (C_out_valid) state_nxt = OUT;
      OUT:       state_nxt = start_take ? COLLECT : IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Field capture and sequence position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      action <= 2'd0;
      dtype  <= 3'd0;
      size   <= 2'd0;
      month  <= 4'd0;
      day    <= 5'd0;
      box_no <= 8'd0;
      sup_bt <= 10'd0;
      sup_gt <= 10'd0;
      sup_m  <= 10'd0;
      sup_pj <= 10'd0;
      step   <= 3'd0;
    end else if (start_take) begin
      action <= D[1:0];
      step   <= 3'd0;
    end else if (fld_take) begin
      step <= step + 3'd1;
      case (exp_fld)
        F_TYPE: dtype  <= D[2:0];
        F_SIZE: size   <= D[1:0];
        F_DATE: begin month <= D[8:5]; day <= D[4:0]; end
        F_BOX:  box_no <= D[7:0];
        F_SUP: begin
          case (sup_idx)
            2'd0:    sup_bt <= D;
            2'd1:    sup_gt <= D;
            2'd2:    sup_m  <= D;
            default: sup_pj <= D;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Remember that the bridge answered until it has been seen idle on a later cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             busy_pend <= 1'b0;
    else if (C_out_valid)   busy_pend <= 1'b1;
    else if (!C_data_r[2])  busy_pend <= 1'b0;
  end

  // Latch the bridge error code with its response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                err_q <= 2'd0;
    else if (state == WAIT_RESP && C_out_valid) err_q <= C_data_r[1:0];
  end

  // Request payload; driven only while a request is being issued or outstanding so it stays stable.
  always_comb begin
    case (action)
      ACT_MAKE: amounts = recipe(dtype, size);
      ACT_SUP:  amounts = {sup_bt, sup_gt, sup_m, sup_pj};
      default:  amounts = 40'd0;
    endcase
    payload = {action, 5'd0, month, day, 8'd0, amounts};
  end

  assign in_req   = (state == ISSUE) || (state == WAIT_RESP);
  assign C_data_w = in_req ? payload : 64'd0;
  assign C_addr   = in_req ? box_no  : 8'd0;

  assign out_valid = (state == OUT);
  assign err_msg   = out_valid ? err_q : 2'd0;
  assign complete  = out_valid && (err_q == 2'd0);

`ifdef BEV_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // Count reported errors, saturating at the top of the range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt_q <= 8'd0;
    else if (out_valid && (err_q != 2'd0) && (err_cnt_q != 8'hFF))
      err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'd0;
`endif

endmodule
